// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - RISC-V load aligner: splits misaligned loads into two beats and merges/extends the result
module load_align_unit #(
  parameter int XLEN           = 64,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_func3,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  localparam int W    = XLEN / 8;
  localparam int OFFW = $clog2(W);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t          state;
  logic [OFFW-1:0] off_q;
  logic [2:0]      func3_q;
  logic [XLEN-1:0] beat0_q;

  logic [2:0] mis_mask;
  logic       in_misaligned;
  logic       in_illegal;
  logic [4:0] span;
  logic       crossing;

  // Shift the two-beat window down to the byte offset, then keep size bytes and extend.
  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] hi,
                                            input logic [XLEN-1:0] lo,
                                            input logic [OFFW-1:0] off,
                                            input logic [2:0]      f3);
    logic [XLEN-1:0] r;
    int              sh;
    r  = XLEN'({hi, lo} >> {off, 3'b000});
    sh = XLEN - (8 << f3[1:0]);
    if (sh > 0) begin
      r = r << sh;
      if (f3[2]) begin
        r = r >> sh;
      end else begin
        r = $unsigned($signed(r) >>> sh);
      end
    end
    return r;
  endfunction

  // Classify the incoming request: illegal encodings and natural-alignment violations.
  always_comb begin
    case (req_func3[1:0])
      2'd0:    mis_mask = 3'b000;
      2'd1:    mis_mask = 3'b001;
      2'd2:    mis_mask = 3'b011;
      default: mis_mask = 3'b111;
    endcase
    in_misaligned = |(req_addr[2:0] & mis_mask);
    in_illegal    = (req_func3 == 3'b111) ||
                    ((XLEN == 32) && ((req_func3 == 3'b011) || (req_func3 == 3'b110)));
  end

  // A latched access needs a second beat when its bytes run past the end of the word.
  assign span     = {{(5-OFFW){1'b0}}, off_q} + (5'd1 << func3_q[1:0]);
  assign crossing = span > 5'(W);

  // Main sequencer; all handshake outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      off_q     <= '0;
      func3_q   <= '0;
      beat0_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q     <= req_addr[OFFW-1:0];
            func3_q   <= req_func3;
            beat0_q   <= '0;
            req_ready <= 1'b0;
            if (in_illegal || (!ALLOW_MISALIGN && in_misaligned)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state     <= REQ0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            end
          end
        end
        REQ0: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            if (crossing) begin
              beat0_q   <= mem_rdata;
              mem_valid <= 1'b1;
              mem_addr  <= mem_addr + XLEN'(W);
              state     <= REQ1;
            end else begin
              rsp_data  <= merge('0, mem_rdata, off_q, func3_q);
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        REQ1: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            rsp_data  <= merge(mem_rdata, beat0_q, off_q, func3_q);
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
